mem_stage_controller: RTL and testbench

Sequencer for the data cache in the MEM stage of the 5-stage pipelined CPU. It watches the EX/MEM memory-request flags, issues exactly one `cache_is_input_valid` request per load/store, and holds the whole pipeline frozen until the cache reports completion. It also captures load data for the MEM/WB register and keeps hit, miss and stall statistics.

---
 rtl/mem_stage_controller.sv | 130 +++++++++++++
 tb/tb_mem_stage_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_controller.sv
// MEM-stage data cache sequencer: issues one cache request per load/store, freezes
// the pipeline until completion, captures load data and keeps access statistics.
module mem_stage_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic                 cache_is_ready,
  input  logic                 cache_is_output_valid,
  input  logic                 cache_is_hit,
  input  logic [31:0]          cache_dout,
  output logic                 cache_is_input_valid,
  output logic                 mem_stall,
  output logic [31:0]          wb_data,
  output logic                 wb_data_valid,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 is_load_q, is_load_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic [CNT_WIDTH-1:0] hit_q, hit_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 req;
  logic                 complete;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign req = ex_mem_read | ex_mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      wb_data_q <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      wb_data_q <= wb_data_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      stall_q   <= stall_d;
    end
  end

  // DONE deliberately ignores req: it still belongs to the instruction just finished.
  always_comb begin
    state_d              = state_q;
    cache_is_input_valid = 1'b0;
    mem_stall            = 1'b0;
    complete             = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          mem_stall = 1'b1;
          if (cache_is_ready) begin
            cache_is_input_valid = 1'b1;
            if (cache_is_output_valid) begin
              complete = 1'b1;
              state_d  = DONE;
            end else begin
              state_d  = WAIT;
            end
          end
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (cache_is_output_valid) begin
          complete = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    is_load_d = is_load_q;
    wb_data_d = wb_data_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    stall_d   = stall_q;
    if (complete) begin
      is_load_d = ex_mem_read;
      if (ex_mem_read) begin
        wb_data_d = cache_dout;
      end
      if (cache_is_hit) begin
        hit_d = sat_inc(hit_q);
      end else begin
        miss_d = sat_inc(miss_q);
      end
    end
    if (mem_stall) begin
      stall_d = sat_inc(stall_q);
    end
  end

  assign wb_data       = wb_data_q;
  assign wb_data_valid = (state_q == DONE) && is_load_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Scoreboard bench for mem_stage_controller: stimulus pushes expected completions,
// a monitor pops and compares them on each DONE cycle.
module tb_mem_stage_controller;

  localparam int CW = 4;  // narrow counters so saturation is reachable

  logic          clk;
  logic          reset;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          cache_is_ready;
  logic          cache_is_output_valid;
  logic          cache_is_hit;
  logic [31:0]   cache_dout;
  logic          cache_is_input_valid;
  logic          mem_stall;
  logic [31:0]   wb_data;
  logic          wb_data_valid;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] stall_cycles;

  mem_stage_controller #(.CNT_WIDTH(CW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ex_mem_read          (ex_mem_read),
    .ex_mem_write         (ex_mem_write),
    .cache_is_ready       (cache_is_ready),
    .cache_is_output_valid(cache_is_output_valid),
    .cache_is_hit         (cache_is_hit),
    .cache_dout           (cache_dout),
    .cache_is_input_valid (cache_is_input_valid),
    .mem_stall            (mem_stall),
    .wb_data              (wb_data),
    .wb_data_valid        (wb_data_valid),
    .hit_count            (hit_count),
    .miss_count           (miss_count),
    .stall_cycles         (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wbv;
    logic [31:0] wbd;
    int          hit;
    int          miss;
    int          stall;
    int          stall_len;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state
  int          m_hit = 0, m_miss = 0, m_stall = 0;
  logic [31:0] m_wb = 32'h0;

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One load/store: rdelay cycles of ready=0, then issue; output_valid k cycles after issue.
  task automatic do_access(input bit rd, input int rdelay, input int k,
                           input logic [31:0] dout, input bit hit, input bit drop);
    exp_t e;
    m_stall = sat(m_stall + rdelay + k + 1);
    if (hit) m_hit = sat(m_hit + 1); else m_miss = sat(m_miss + 1);
    if (rd) m_wb = dout;
    e.wbv = rd; e.wbd = m_wb; e.hit = m_hit; e.miss = m_miss;
    e.stall = m_stall; e.stall_len = rdelay + k + 1;
    exp_q.push_back(e);
    $display("access %s rdelay=%0d k=%0d dout=%h hit=%0d", rd ? "load" : "store", rdelay, k, dout, hit);

    ex_mem_read = rd; ex_mem_write = !rd;
    cache_is_output_valid = 1'b0;
    cache_is_ready = (rdelay == 0);
    repeat (rdelay) tick;
    cache_is_ready = 1'b1;
    if (k == 0) begin
      cache_is_output_valid = 1'b1; cache_dout = dout; cache_is_hit = hit;
    end
    tick;
    cache_is_ready = 1'b0;
    if (k > 0) begin
      cache_is_output_valid = 1'b0;
      repeat (k - 1) tick;
      cache_is_output_valid = 1'b1; cache_dout = dout; cache_is_hit = hit;
      tick;
    end
    // DONE cycle: a stray output_valid here must be ignored
    cache_is_output_valid = drop; cache_dout = 32'h5555_AAAA; cache_is_hit = 1'b1;
    tick;
    if (drop) begin
      ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      cache_is_output_valid = 1'b1;  // stray in IDLE with no request
      tick;
      cache_is_output_valid = 1'b0;
    end
  endtask

  // Monitor: counts issue pulses and stall cycles per access, compares on DONE.
  initial begin
    int   iv_cnt = 0, st_cnt = 0;
    logic prev_stall = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        iv_cnt = 0; st_cnt = 0; prev_stall = 1'b0;
      end else begin
        if (prev_stall && !mem_stall && (ex_mem_read || ex_mem_write)) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got completion expected none");
          end else begin
            e = exp_q.pop_front();
            check("wb_data_valid", 64'(wb_data_valid), 64'(e.wbv));
            check("wb_data", 64'(wb_data), 64'(e.wbd));
            check("hit_count", 64'(hit_count), 64'(e.hit));
            check("miss_count", 64'(miss_count), 64'(e.miss));
            check("stall_cycles", 64'(stall_cycles), 64'(e.stall));
            check("issue_pulses", 64'(iv_cnt), 64'd1);
            check("stall_len", 64'(st_cnt), 64'(e.stall_len));
            $display("done wbv=%0d wb=%h hit=%0d miss=%0d stall=%0d pulses=%0d len=%0d",
                     wb_data_valid, wb_data, hit_count, miss_count, stall_cycles, iv_cnt, st_cnt);
          end
          iv_cnt = int'(cache_is_input_valid);
          st_cnt = int'(mem_stall);
        end else begin
          iv_cnt += int'(cache_is_input_valid);
          st_cnt += int'(mem_stall);
        end
        prev_stall = mem_stall;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    cache_is_ready = 1'b0; cache_is_output_valid = 1'b0;
    cache_is_hit = 1'b0; cache_dout = 32'h0;
    repeat (3) tick;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs",
            64'({cache_is_input_valid, mem_stall, wb_data_valid, wb_data,
                 hit_count, miss_count, stall_cycles}), 64'd0);
      tick;
    end

    do_access(1'b1, 0, 3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    do_access(1'b0, 0, 0, 32'h1111_1111, 1'b1, 1'b1);
    do_access(1'b1, 5, 1, 32'h1234_5678, 1'b1, 1'b1);
    do_access(1'b1, 0, 2, 32'hA5A5_A5A5, 1'b0, 1'b0);
    do_access(1'b1, 0, 0, 32'h0F0F_0F0F, 1'b1, 1'b1);

    // reset in WAIT abandons the access
    $display("access load aborted by reset in WAIT");
    ex_mem_read = 1'b1; cache_is_ready = 1'b1; cache_is_output_valid = 1'b0;
    tick;
    cache_is_ready = 1'b0;
    tick;
    @(negedge clk);
    check("wait_stall", 64'(mem_stall), 64'd1);
    check("wait_no_issue", 64'(cache_is_input_valid), 64'd0);
    tick;
    reset = 1'b1; ex_mem_read = 1'b0;
    tick;
    reset = 1'b0;
    cache_is_output_valid = 1'b1; cache_is_hit = 1'b1; cache_dout = 32'hFFFF_FFFF;
    m_hit = 0; m_miss = 0; m_stall = 0; m_wb = 32'h0;
    @(negedge clk);
    check("post_reset_stall", 64'(mem_stall), 64'd0);
    check("post_reset_issue", 64'(cache_is_input_valid), 64'd0);
    tick;
    cache_is_output_valid = 1'b0;
    @(negedge clk);
    check("post_reset_counters", 64'({hit_count, miss_count, stall_cycles}), 64'd0);
    check("post_reset_wb", 64'({wb_data_valid, wb_data}), 64'd0);
    check("post_reset_idle_stall", 64'(mem_stall), 64'd0);
    tick;

    do_access(1'b0, 0, 2, 32'h7777_7777, 1'b0, 1'b1);

    repeat (3) tick;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
